mem_lmsm_seq: RTL and testbench

//  MEM-stage sequencer for load-multiple (LM) / store-multiple (SM), fed by the EX/MEM pipeline register.

---
 rtl/mem_lmsm_if.sv | 45 ++++
 rtl/mem_lmsm_seq.sv | 144 ++++++++++++++
 tb/tb_mem_lmsm_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lmsm_if.sv
// EX/MEM-side bundle for the LM/SM sequencer: pipeline controls, reg-file ports and data-memory ports.
// master = pipeline/memory environment, slave = sequencer.
interface mem_lmsm_if #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int NREG = 8
);
    localparam int RW = $clog2(NREG);

    logic          valid;
    logic          lm;
    logic          sm;
    logic [8:0]    imm;
    logic [AW-1:0] base;
    logic          adv;
    logic          kill;

    logic [RW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    logic          wb_en;
    logic [RW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    logic          stall;
    logic          busy;

    modport master (
        output valid, lm, sm, imm, base, adv, kill, rf_rdata, mem_rdata,
        input  rf_raddr, mem_addr, mem_wdata, mem_we, mem_re,
               wb_en, wb_addr, wb_data, stall, busy
    );

    modport slave (
        input  valid, lm, sm, imm, base, adv, kill, rf_rdata, mem_rdata,
        output rf_raddr, mem_addr, mem_wdata, mem_we, mem_re,
               wb_en, wb_addr, wb_data, stall, busy
    );
endinterface

// File: rtl/mem_lmsm_seq.sv
// MEM-stage load-multiple / store-multiple sequencer: one memory access per set mask bit,
// lowest register first, stalling the front of the pipe while the burst is in flight.
//
// state | meaning
// IDLE  | no LM/SM in progress; start latches mask/base/op from EX/MEM
// RUN   | one access per cycle for the lowest remaining mask bit
// DRAIN | LM only: final read's write-back, no new access
// DONE  | burst finished, pipe released; wait for EX/MEM to advance
module mem_lmsm_seq #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input logic       clk,
    input logic       rst,
    mem_lmsm_if.slave bus
);
    localparam int RW = $clog2(NREG);
    localparam int CW = RW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NREG-1:0] mask;
    logic [NREG-1:0] mask_clr;
    logic [AW-1:0]   base_q;
    logic            op_lm;
    logic [CW-1:0]   cnt;
    logic            wb_pend;
    logic [RW-1:0]   wb_k;

    logic            abort;
    logic            start;
    logic [RW-1:0]   k;
    logic [AW-1:0]   addr_cur;
    logic            unused_imm;

    assign unused_imm = bus.imm[8];

    // Reset gates the outputs like a kill so nothing leaks out during the reset cycle.
    assign abort = rst | bus.kill;
    assign start = (state == IDLE) & bus.valid & (bus.lm | bus.sm)
                 & (bus.imm[NREG-1:0] != '0) & ~abort;

    always_comb begin
        k = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask[i]) k = RW'(i);
        end
    end

    assign mask_clr = mask & ~(NREG'(1) << k);
    assign addr_cur = base_q + AW'({cnt, 1'b0});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.stall     = 1'b0;
        bus.rf_raddr  = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    bus.stall = start;
                    if (start) state_nxt = RUN;
                end
                RUN: begin
                    bus.stall    = 1'b1;
                    bus.mem_addr = addr_cur;
                    if (op_lm) begin
                        bus.mem_re = 1'b1;
                    end else begin
                        bus.mem_we    = 1'b1;
                        bus.rf_raddr  = k;
                        bus.mem_wdata = bus.rf_rdata;
                    end
                    if (mask_clr == '0) state_nxt = op_lm ? DRAIN : DONE;
                end
                DRAIN: begin
                    bus.stall = 1'b1;
                    state_nxt = DONE;
                end
                DONE: begin
                    if (bus.adv) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after the strobe, so the destination index is carried along.
    always_comb begin
        bus.wb_en   = wb_pend & ~abort;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        if (bus.wb_en) begin
            bus.wb_addr = wb_k;
            bus.wb_data = bus.mem_rdata;
        end
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= '0;
            base_q  <= '0;
            op_lm   <= 1'b0;
            cnt     <= '0;
            wb_pend <= 1'b0;
            wb_k    <= '0;
        end else begin
            wb_pend <= (state == RUN) & op_lm & ~bus.kill;
            wb_k    <= ((state == RUN) && op_lm) ? k : '0;
            if (bus.kill) begin
                mask <= '0;
                cnt  <= '0;
            end else if (start) begin
                mask   <= bus.imm[NREG-1:0];
                base_q <= bus.base;
                op_lm  <= bus.lm;
                cnt    <= '0;
            end else if (state == RUN) begin
                mask <= mask_clr;
                cnt  <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_lmsm_seq.sv
// Bench for mem_lmsm_seq: memory/reg-file environment, negedge monitor and a golden
// scoreboard of expected accesses and write-backs built from an independent model.
module tb_mem_lmsm_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_lmsm_if #(.AW(16), .DW(16), .NREG(8)) bus ();
    mem_lmsm_seq #(.AW(16), .DW(16), .NREG(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {logic we; logic [15:0] addr; logic [15:0] data;} acc_t;
    typedef struct packed {logic [2:0] r; logic [15:0] data;} wb_t;

    acc_t obs_acc[$];
    acc_t exp_acc[$];
    wb_t  obs_wb[$];
    wb_t  exp_wb[$];
    int   acc_rd = 0;
    int   wb_rd = 0;
    int   stall_cnt = 0;
    int   both_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem  [0:65535];
    logic [15:0] gmem [0:65535];
    logic [15:0] rf   [0:7];
    logic [15:0] grf  [0:7];
    logic        pl_we;
    logic        pl_rf;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;

    assign bus.rf_rdata = rf[bus.rf_raddr];

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.wb_en)  rf[bus.wb_addr] <= bus.wb_data;
        if (pl_we) begin
            if (pl_rf) rf[pl_addr[2:0]] <= pl_data;
            else       mem[pl_addr] <= pl_data;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_we | bus.mem_re)
            obs_acc.push_back({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 16'h0});
        if (bus.wb_en) obs_wb.push_back({bus.wb_addr, bus.wb_data});
        if (bus.stall) stall_cnt <= stall_cnt + 1;
        if (bus.mem_we & bus.mem_re) both_cnt <= both_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [58:0] outs();
        return {bus.stall, bus.busy, bus.mem_we, bus.mem_re, bus.wb_en, bus.mem_addr,
                bus.mem_wdata, bus.rf_raddr, bus.wb_addr, bus.wb_data};
    endfunction

    task automatic put_mem(input logic [15:0] a, input logic [15:0] d);
        gmem[a] = d; pl_rf = 1'b0; pl_addr = a; pl_data = d; pl_we = 1'b1;
        @(posedge clk); #1 pl_we = 1'b0;
    endtask

    task automatic put_rf(input logic [2:0] r, input logic [15:0] d);
        grf[r] = d; pl_rf = 1'b1; pl_addr = {13'h0, r}; pl_data = d; pl_we = 1'b1;
        @(posedge clk); #1 pl_we = 1'b0;
    endtask

    // Golden model: ascending register order, address = base + 2*access index.
    task automatic push_expected(input bit is_lm, input logic [7:0] msk, input logic [15:0] b);
        int j = 0;
        logic [15:0] a;
        for (int r = 0; r < 8; r++) begin
            if (msk[r]) begin
                a = b + 16'(2 * j);
                if (is_lm) begin
                    exp_acc.push_back({1'b0, a, 16'h0});
                    exp_wb.push_back({3'(r), gmem[a]});
                    grf[r] = gmem[a];
                end else begin
                    exp_acc.push_back({1'b1, a, grf[r]});
                    gmem[a] = grf[r];
                end
                j++;
            end
        end
    endtask

    task automatic do_op(input bit is_lm, input logic [7:0] msk, input logic [15:0] b,
                         output bit to);
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.lm = is_lm; bus.sm = ~is_lm; bus.imm = {1'b1, msk};
        bus.base = b; bus.adv = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.busy && !bus.stall) begin to = 1'b0; break; end
        end
        @(posedge clk); #1 bus.adv = 1'b1;
        @(posedge clk); #1;
        bus.adv = 1'b0; bus.valid = 1'b0; bus.lm = 1'b0; bus.sm = 1'b0; bus.imm = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid = 1'b1; bus.lm = 1'b1; bus.imm = 9'h0FF; bus.base = 16'h0100;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (outs() !== 59'h0) begin
                errors++; $display("FAIL reset_outputs got %h required 0", outs());
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.valid = 1'b0; bus.lm = 1'b0; bus.imm = '0;
        @(negedge clk);
        checks++;
        if (outs() !== 59'h0) begin
            errors++; $display("FAIL reset_release got %h required 0", outs());
        end
    endtask

    task automatic test_lm_basic();
        bit to; int s0; acc_t e, o; wb_t ew, ow;
        put_mem(16'h0100, 16'h00A1); put_mem(16'h0102, 16'h00B2); put_mem(16'h0104, 16'h00C3);
        push_expected(1'b1, 8'b1000_0101, 16'h0100);
        s0 = stall_cnt;
        do_op(1'b1, 8'b1000_0101, 16'h0100, to);
        checks++; if (to) begin errors++; $display("FAIL lm_basic_done got timeout required done"); end
        checks++;
        if (stall_cnt - s0 != 5) begin errors++; $display("FAIL lm_basic_stall got %0d required 5", stall_cnt - s0); end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front(); checks++;
            if (acc_rd >= obs_acc.size()) begin errors++; $display("FAIL lm_basic_acc got none required %h", e); end
            else begin
                o = obs_acc[acc_rd]; acc_rd++;
                if (o !== e) begin errors++; $display("FAIL lm_basic_acc got %h required %h", o, e); end
            end
        end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); checks++;
            if (wb_rd >= obs_wb.size()) begin errors++; $display("FAIL lm_basic_wb got none required %h", ew); end
            else begin
                ow = obs_wb[wb_rd]; wb_rd++;
                if (ow !== ew) begin errors++; $display("FAIL lm_basic_wb got %h required %h", ow, ew); end
            end
        end
        checks++;
        if (acc_rd != obs_acc.size() || wb_rd != obs_wb.size()) begin
            errors++; $display("FAIL lm_basic_extra got acc %0d wb %0d required acc %0d wb %0d",
                               obs_acc.size(), obs_wb.size(), acc_rd, wb_rd);
            acc_rd = obs_acc.size(); wb_rd = obs_wb.size();
        end
        checks++;
        if ({rf[0], rf[2], rf[7]} !== {16'h00A1, 16'h00B2, 16'h00C3}) begin
            errors++; $display("FAIL lm_basic_rf got %h %h %h required 00a1 00b2 00c3", rf[0], rf[2], rf[7]);
        end
    endtask

    task automatic test_sm_basic();
        bit to; int s0; acc_t e, o;
        put_rf(3'd0, 16'h1111); put_rf(3'd1, 16'h2222);
        push_expected(1'b0, 8'h03, 16'h0200);
        s0 = stall_cnt;
        do_op(1'b0, 8'h03, 16'h0200, to);
        checks++; if (to) begin errors++; $display("FAIL sm_basic_done got timeout required done"); end
        checks++;
        if (stall_cnt - s0 != 3) begin errors++; $display("FAIL sm_basic_stall got %0d required 3", stall_cnt - s0); end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front(); checks++;
            if (acc_rd >= obs_acc.size()) begin errors++; $display("FAIL sm_basic_acc got none required %h", e); end
            else begin
                o = obs_acc[acc_rd]; acc_rd++;
                if (o !== e) begin errors++; $display("FAIL sm_basic_acc got %h required %h", o, e); end
            end
        end
        checks++;
        if (acc_rd != obs_acc.size() || wb_rd != obs_wb.size()) begin
            errors++; $display("FAIL sm_basic_extra got acc %0d wb %0d required acc %0d wb %0d",
                               obs_acc.size(), obs_wb.size(), acc_rd, wb_rd);
            acc_rd = obs_acc.size(); wb_rd = obs_wb.size();
        end
        checks++;
        if ({mem[16'h0200], mem[16'h0202]} !== {gmem[16'h0200], gmem[16'h0202]}) begin
            errors++; $display("FAIL sm_basic_mem got %h %h required %h %h",
                               mem[16'h0200], mem[16'h0202], gmem[16'h0200], gmem[16'h0202]);
        end
    endtask

    task automatic test_lm_wrap();
        bit to; int s0; acc_t e, o; wb_t ew, ow;
        for (int j = 0; j < 8; j++) put_mem(16'hFFFC + 16'(2 * j), {8'hD0, 8'(j * 17 + 3)});
        push_expected(1'b1, 8'hFF, 16'hFFFC);
        s0 = stall_cnt;
        do_op(1'b1, 8'hFF, 16'hFFFC, to);
        checks++; if (to) begin errors++; $display("FAIL lm_wrap_done got timeout required done"); end
        checks++;
        if (stall_cnt - s0 != 10) begin errors++; $display("FAIL lm_wrap_stall got %0d required 10", stall_cnt - s0); end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front(); checks++;
            if (acc_rd >= obs_acc.size()) begin errors++; $display("FAIL lm_wrap_acc got none required %h", e); end
            else begin
                o = obs_acc[acc_rd]; acc_rd++;
                if (o !== e) begin errors++; $display("FAIL lm_wrap_acc got %h required %h", o, e); end
            end
        end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); checks++;
            if (wb_rd >= obs_wb.size()) begin errors++; $display("FAIL lm_wrap_wb got none required %h", ew); end
            else begin
                ow = obs_wb[wb_rd]; wb_rd++;
                if (ow !== ew) begin errors++; $display("FAIL lm_wrap_wb got %h required %h", ow, ew); end
            end
        end
        checks++;
        if (acc_rd != obs_acc.size() || wb_rd != obs_wb.size()) begin
            errors++; $display("FAIL lm_wrap_extra got acc %0d wb %0d required acc %0d wb %0d",
                               obs_acc.size(), obs_wb.size(), acc_rd, wb_rd);
            acc_rd = obs_acc.size(); wb_rd = obs_wb.size();
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rf[r] !== grf[r]) begin errors++; $display("FAIL lm_wrap_rf%0d got %h required %h", r, rf[r], grf[r]); end
        end
    endtask

    task automatic test_zero_mask();
        int a0, w0;
        a0 = obs_acc.size(); w0 = obs_wb.size();
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.lm = 1'b1; bus.imm = 9'h100; bus.base = 16'h0700;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL zero_mask_idle got stall %b busy %b required 0 0", bus.stall, bus.busy);
            end
        end
        @(posedge clk); #1;
        bus.valid = 1'b0; bus.lm = 1'b0; bus.imm = '0;
        @(negedge clk);
        checks++;
        if (obs_acc.size() != a0 || obs_wb.size() != w0) begin
            errors++; $display("FAIL zero_mask_strobes got acc %0d wb %0d required %0d %0d",
                               obs_acc.size(), obs_wb.size(), a0, w0);
        end
        acc_rd = obs_acc.size(); wb_rd = obs_wb.size();
    endtask

    task automatic test_abort(input bit use_rst);
        int a0, w0;
        for (int j = 0; j < 8; j++) put_mem(16'h0300 + 16'(2 * j), 16'hE000 + 16'(j));
        a0 = obs_acc.size(); w0 = obs_wb.size();
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.lm = 1'b1; bus.sm = 1'b0; bus.imm = 9'h0FF;
        bus.base = 16'h0300; bus.adv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (use_rst) rst = 1'b1;
        else         bus.kill = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_acc.size() != a0 + 1) begin
            errors++; $display("FAIL abort%0d_access got %0d required %0d", use_rst, obs_acc.size() - a0, 1);
        end
        checks++;
        if (obs_wb.size() != w0) begin
            errors++; $display("FAIL abort%0d_wb got %0d required 0", use_rst, obs_wb.size() - w0);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.kill = 1'b0; bus.valid = 1'b0; bus.lm = 1'b0; bus.imm = '0;
        @(negedge clk);
        checks++;
        if (outs() !== 59'h0) begin
            errors++; $display("FAIL abort%0d_idle got %h required 0", use_rst, outs());
        end
        repeat (4) @(negedge clk);
        checks++;
        if (obs_acc.size() != a0 + 1 || obs_wb.size() != w0) begin
            errors++; $display("FAIL abort%0d_quiet got acc %0d wb %0d required 1 0",
                               use_rst, obs_acc.size() - a0, obs_wb.size() - w0);
        end
        checks++;
        if (obs_acc.size() <= a0 || obs_acc[a0] !== {1'b0, 16'h0300, 16'h0}) begin
            errors++; $display("FAIL abort%0d_first got %h required %h", use_rst,
                               (obs_acc.size() > a0) ? obs_acc[a0] : 33'h0, {1'b0, 16'h0300, 16'h0});
        end
        acc_rd = obs_acc.size(); wb_rd = obs_wb.size();
    endtask

    task automatic test_adv_hold();
        bit to; int s0, a0; acc_t e, o;
        put_rf(3'd4, 16'h4444);
        push_expected(1'b0, 8'h10, 16'h0400);
        s0 = stall_cnt;
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.sm = 1'b1; bus.lm = 1'b0; bus.imm = 9'h010;
        bus.base = 16'h0400; bus.adv = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.busy && !bus.stall) begin to = 1'b0; break; end
        end
        checks++; if (to) begin errors++; $display("FAIL adv_hold_done got timeout required done"); end
        a0 = obs_acc.size();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1 || bus.stall !== 1'b0 || obs_acc.size() != a0) begin
                errors++; $display("FAIL adv_hold_wait got busy %b stall %b new_acc %0d required 1 0 0",
                                   bus.busy, bus.stall, obs_acc.size() - a0);
            end
        end
        @(posedge clk); #1 bus.adv = 1'b1;
        @(posedge clk); #1;
        bus.adv = 1'b0; bus.valid = 1'b0; bus.sm = 1'b0; bus.imm = '0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL adv_hold_idle got busy %b stall %b required 0 0", bus.busy, bus.stall);
        end
        checks++;
        if (stall_cnt - s0 != 2) begin errors++; $display("FAIL adv_hold_stall got %0d required 2", stall_cnt - s0); end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front(); checks++;
            if (acc_rd >= obs_acc.size()) begin errors++; $display("FAIL adv_hold_acc got none required %h", e); end
            else begin
                o = obs_acc[acc_rd]; acc_rd++;
                if (o !== e) begin errors++; $display("FAIL adv_hold_acc got %h required %h", o, e); end
            end
        end
        checks++;
        if (acc_rd != obs_acc.size() || wb_rd != obs_wb.size()) begin
            errors++; $display("FAIL adv_hold_extra got acc %0d wb %0d required acc %0d wb %0d",
                               obs_acc.size(), obs_wb.size(), acc_rd, wb_rd);
            acc_rd = obs_acc.size(); wb_rd = obs_wb.size();
        end
    endtask

    task automatic test_back_to_back();
        bit to1, to2; int s0; acc_t e, o; wb_t ew, ow;
        put_rf(3'd5, 16'h5555); put_rf(3'd6, 16'h6666);
        push_expected(1'b0, 8'h60, 16'h0500);
        push_expected(1'b1, 8'h03, 16'h0500);
        s0 = stall_cnt;
        do_op(1'b0, 8'h60, 16'h0500, to1);
        do_op(1'b1, 8'h03, 16'h0500, to2);
        checks++;
        if (to1 || to2) begin errors++; $display("FAIL b2b_done got timeout %b%b required 00", to1, to2); end
        checks++;
        if (stall_cnt - s0 != 7) begin errors++; $display("FAIL b2b_stall got %0d required 7", stall_cnt - s0); end
        while (exp_acc.size() > 0) begin
            e = exp_acc.pop_front(); checks++;
            if (acc_rd >= obs_acc.size()) begin errors++; $display("FAIL b2b_acc got none required %h", e); end
            else begin
                o = obs_acc[acc_rd]; acc_rd++;
                if (o !== e) begin errors++; $display("FAIL b2b_acc got %h required %h", o, e); end
            end
        end
        while (exp_wb.size() > 0) begin
            ew = exp_wb.pop_front(); checks++;
            if (wb_rd >= obs_wb.size()) begin errors++; $display("FAIL b2b_wb got none required %h", ew); end
            else begin
                ow = obs_wb[wb_rd]; wb_rd++;
                if (ow !== ew) begin errors++; $display("FAIL b2b_wb got %h required %h", ow, ew); end
            end
        end
        checks++;
        if ({rf[0], rf[1]} !== {16'h5555, 16'h6666}) begin
            errors++; $display("FAIL b2b_rf got %h %h required 5555 6666", rf[0], rf[1]);
        end
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL strobe_exclusive got %0d required 0", both_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        bus.valid = 1'b0; bus.lm = 1'b0; bus.sm = 1'b0; bus.imm = '0; bus.base = '0;
        bus.adv = 1'b0; bus.kill = 1'b0;
        pl_we = 1'b0; pl_rf = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset();
        test_lm_basic();
        test_sm_basic();
        test_lm_wrap();
        test_zero_mask();
        test_abort(1'b0);
        test_abort(1'b1);
        test_adv_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
